// File: rtl/psram_slave_model.sv
// psram_slave_model: octal-DDR PSRAM responder with byte array, DQS-strobed reads and DQS-masked writes
module psram_slave_model #(
  parameter int MEM_DEPTH = 256,
  parameter int MEM_AW = $clog2(MEM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        cfg_rcmd_i,
  input  logic [7:0]        cfg_wcmd_i,
  input  logic [7:0]        cfg_rlc_i,
  input  logic [7:0]        cfg_wlc_i,
  input  logic              psram_sck_i,
  input  logic              psram_ce_i,
  input  logic [7:0]        psram_io_in_i,
  output logic [7:0]        psram_io_out_o,
  output logic [7:0]        psram_io_en_o,
  input  logic              psram_dqs_in_i,
  output logic              psram_dqs_out_o,
  output logic              psram_dqs_en_o,
  input  logic [MEM_AW-1:0] bd_addr_i,
  output logic [7:0]        bd_data_o,
  output logic              busy_o,
  output logic              cmd_err_o
);
  typedef enum logic [2:0] {IDLE, INST, ADDR, LATN, WDATA, RDATA, IGNORE} state_t;
  state_t state, state_n;
  logic sck_q, rd, dqs_out, cmd_err;
  logic [1:0] acnt;
  logic [7:0] lat_cnt, io_out;
  logic [31:0] addr;
  logic [7:0] mem [MEM_DEPTH];
  logic rise, fall, sck_edge, go, rmatch, wmatch, inst_edge, addr_edge, last_lat, data_edge, wr_en, rd_edge;
  assign rise = psram_sck_i & ~sck_q;
  assign fall = ~psram_sck_i & sck_q;
  assign sck_edge = rise | fall;
  assign go = ~psram_ce_i;
  assign rmatch = psram_io_in_i == cfg_rcmd_i;
  assign wmatch = psram_io_in_i == cfg_wcmd_i;
  assign inst_edge = go && state == INST && rise;
  // address bytes land on rise, fall, rise, fall; the fall right after the opcode is skipped
  assign addr_edge = go && state == ADDR && (acnt[0] ? fall : rise);
  assign last_lat = go && state == LATN && rise && lat_cnt == 8'd0;
  assign data_edge = last_lat || (go && (state == WDATA || state == RDATA) && sck_edge);
  assign wr_en = data_edge && !rd && psram_dqs_in_i;
  assign rd_edge = data_edge && rd;
  always_comb begin
    state_n = state;
    if (psram_ce_i) state_n = IDLE;
    else case (state)
      IDLE: state_n = INST;
      INST: if (rise) state_n = (rmatch || wmatch) ? ADDR : IGNORE;
      ADDR: if (addr_edge && acnt == 2'd3) state_n = LATN;
      LATN: if (last_lat) state_n = rd ? RDATA : WDATA;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      sck_q <= 1'b0;
      rd <= 1'b0;
      dqs_out <= 1'b0;
      cmd_err <= 1'b0;
      acnt <= 2'd0;
      lat_cnt <= 8'd0;
      io_out <= 8'd0;
      addr <= 32'd0;
    end else begin
      state <= state_n;
      sck_q <= psram_sck_i;
      cmd_err <= inst_edge && !rmatch && !wmatch;
      if (inst_edge) begin
        rd <= rmatch;
        acnt <= 2'd0;
      end
      if (addr_edge) begin
        addr <= {addr[23:0], psram_io_in_i};
        acnt <= acnt + 2'd1;
      end
      if (addr_edge && acnt == 2'd3) lat_cnt <= rd ? cfg_rlc_i : cfg_wlc_i;
      else if (go && state == LATN && rise && lat_cnt != 8'd0) lat_cnt <= lat_cnt - 8'd1;
      if (data_edge) addr <= addr + 32'd1;
      if (rd_edge) io_out <= mem[addr[MEM_AW-1:0]];
      dqs_out <= rd_edge ? ~dqs_out : (go && state == RDATA && dqs_out);
    end
  end
  always_ff @(posedge clk_i) if (wr_en) mem[addr[MEM_AW-1:0]] <= psram_io_in_i;
  assign psram_io_out_o = io_out;
  assign psram_io_en_o = {8{state == RDATA}};
  assign psram_dqs_out_o = dqs_out;
  assign psram_dqs_en_o = state == RDATA;
  assign bd_data_o = mem[bd_addr_i];
  assign busy_o = state != IDLE;
  assign cmd_err_o = cmd_err;
endmodule

// File: tb/tb_psram_slave_model.sv
// tb_psram_slave_model: directed PSRAM bursts checked every cycle against a transaction-level byte model
module tb_psram_slave_model;
  localparam int K_NONE = 0, K_WR = 1, K_RD = 2, K_ERR = 3;
  logic clk_i = 1'b0, rst_n_i = 1'b0;
  logic [7:0] cfg_rcmd_i = 8'h20, cfg_wcmd_i = 8'hA0, cfg_rlc_i = 8'd3, cfg_wlc_i = 8'd2;
  logic psram_sck_i = 1'b0, psram_ce_i = 1'b1, psram_dqs_in_i = 1'b0;
  logic [7:0] psram_io_in_i = 8'h00, bd_addr_i = 8'h00;
  logic [7:0] psram_io_out_o, psram_io_en_o, bd_data_o;
  logic psram_dqs_out_o, psram_dqs_en_o, busy_o, cmd_err_o;
  psram_slave_model #(.MEM_DEPTH(256)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cfg_rcmd_i(cfg_rcmd_i), .cfg_wcmd_i(cfg_wcmd_i), .cfg_rlc_i(cfg_rlc_i), .cfg_wlc_i(cfg_wlc_i),
    .psram_sck_i(psram_sck_i), .psram_ce_i(psram_ce_i),
    .psram_io_in_i(psram_io_in_i), .psram_io_out_o(psram_io_out_o), .psram_io_en_o(psram_io_en_o),
    .psram_dqs_in_i(psram_dqs_in_i), .psram_dqs_out_o(psram_dqs_out_o), .psram_dqs_en_o(psram_dqs_en_o),
    .bd_addr_i(bd_addr_i), .bd_data_o(bd_data_o), .busy_o(busy_o), .cmd_err_o(cmd_err_o)
  );
  always #5 clk_i = ~clk_i;
  logic [7:0] mm [256];
  logic known [256];
  logic [31:0] ma = 32'd0;
  logic exp_busy = 1'b0, exp_en = 1'b0, exp_dqs = 1'b0, exp_err = 1'b0, chk_on = 1'b0;
  logic [7:0] exp_io = 8'h00;
  logic [7:0] dq[$], rdq[$];
  logic mq[$];
  logic dqs_prev = 1'b0;
  int checks = 0, errors = 0, toggles = 0, err_pulses = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk_i) begin
    #1;
    if (chk_on) begin
      chk("busy", busy_o, exp_busy);
      chk("io_en", psram_io_en_o, {8{exp_en}});
      chk("dqs_en", psram_dqs_en_o, exp_en);
      chk("dqs_out", psram_dqs_out_o, exp_dqs);
      chk("cmd_err", cmd_err_o, exp_err);
      if (exp_en) chk("io_out", psram_io_out_o, exp_io);
      if (known[bd_addr_i]) chk("bd_data", bd_data_o, mm[bd_addr_i]);
    end
  end
  always @(posedge clk_i) begin
    #1;
    if (psram_dqs_out_o !== dqs_prev) toggles++;
    dqs_prev = psram_dqs_out_o;
    if (cmd_err_o) err_pulses++;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  task automatic drive(input logic s, input logic [7:0] d, input logic m, input int k);
    @(negedge clk_i);
    psram_sck_i = s;
    psram_io_in_i = d;
    psram_dqs_in_i = m;
    if (k == K_WR) begin
      if (m) begin
        mm[ma[7:0]] = d;
        known[ma[7:0]] = 1'b1;
      end
      ma = ma + 32'd1;
    end else if (k == K_RD) begin
      exp_en = 1'b1;
      exp_io = mm[ma[7:0]];
      exp_dqs = ~exp_dqs;
      ma = ma + 32'd1;
    end else if (k == K_ERR) exp_err = 1'b1;
    @(negedge clk_i);
    exp_err = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask
  task automatic ce_set(input logic v);
    @(negedge clk_i);
    psram_ce_i = v;
    if (v) begin
      psram_sck_i = 1'b0;
      exp_busy = 1'b0;
      exp_en = 1'b0;
      exp_dqs = 1'b0;
    end else exp_busy = 1'b1;
    repeat (3) @(negedge clk_i);
  endtask
  task automatic cmd_addr(input logic [7:0] op, input logic [31:0] a, input int lc);
    ce_set(1'b0);
    drive(1'b1, op, 1'b0, K_NONE);
    drive(1'b0, 8'h00, 1'b0, K_NONE);
    drive(1'b1, a[31:24], 1'b0, K_NONE);
    drive(1'b0, a[23:16], 1'b0, K_NONE);
    drive(1'b1, a[15:8], 1'b0, K_NONE);
    drive(1'b0, a[7:0], 1'b0, K_NONE);
    ma = a;
    repeat (lc) begin
      drive(1'b1, 8'hEE, 1'b1, K_NONE);
      drive(1'b0, 8'hEE, 1'b1, K_NONE);
    end
  endtask
  task automatic write_burst(input logic [31:0] a, input int lc);
    cfg_wlc_i = 8'(lc);
    cmd_addr(8'hA0, a, lc);
    for (int i = 0; i < dq.size(); i++) drive(i % 2 == 0, dq[i], mq[i], K_WR);
    ce_set(1'b1);
  endtask
  task automatic read_burst(input logic [31:0] a, input int lc, input int n);
    cfg_rlc_i = 8'(lc);
    cmd_addr(8'h20, a, lc);
    rdq.delete();
    for (int i = 0; i < n; i++) begin
      drive(i % 2 == 0, 8'h00, 1'b0, K_RD);
      rdq.push_back(psram_io_out_o);
    end
    ce_set(1'b1);
  endtask
  task automatic bd_is(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk_i);
    bd_addr_i = a;
    #1;
    chk("bd_literal", bd_data_o, v);
  endtask
  initial begin
    logic [7:0] exp_rd [4];
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_io_out", psram_io_out_o, 8'h00);
    chk("rst_io_en", psram_io_en_o, 8'h00);
    chk("rst_dqs_out", psram_dqs_out_o, 1'b0);
    chk("rst_dqs_en", psram_dqs_en_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cmd_err", cmd_err_o, 1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    chk_on = 1'b1;
    dq.delete();
    mq.delete();
    for (int i = 0; i < 256; i++) begin
      dq.push_back(8'(i) ^ 8'h5C);
      mq.push_back(1'b1);
    end
    write_burst(32'h0, 2);
    dq = '{8'h11, 8'h22, 8'h33, 8'h44};
    mq = '{1'b1, 1'b1, 1'b1, 1'b1};
    write_burst(32'h10, 2);
    bd_is(8'h10, 8'h11);
    bd_is(8'h11, 8'h22);
    bd_is(8'h12, 8'h33);
    bd_is(8'h13, 8'h44);
    toggles = 0;
    read_burst(32'h12, 3, 4);
    exp_rd = '{8'h33, 8'h44, 8'h48, 8'h49};
    chk("read_len", rdq.size(), 4);
    for (int i = 0; i < 4 && i < rdq.size(); i++) chk("read_literal", rdq[i], exp_rd[i]);
    chk("dqs_toggles", toggles, 4);
    dq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    mq = '{1'b1, 1'b0, 1'b1, 1'b0};
    write_burst(32'h20, 2);
    bd_is(8'h20, 8'hAA);
    bd_is(8'h21, 8'h7D);
    bd_is(8'h22, 8'hCC);
    bd_is(8'h23, 8'h7F);
    dq = '{8'hE1, 8'hE2};
    mq = '{1'b1, 1'b1};
    write_burst(32'h1FF, 1);
    bd_is(8'hFF, 8'hE1);
    bd_is(8'h00, 8'hE2);
    err_pulses = 0;
    ce_set(1'b0);
    drive(1'b1, 8'h5A, 1'b0, K_ERR);
    for (int i = 0; i < 6; i++) drive(i % 2 == 1, 8'h77, 1'b1, K_NONE);
    ce_set(1'b1);
    chk("err_pulses", err_pulses, 1);
    cfg_wlc_i = 8'd0;
    ce_set(1'b0);
    drive(1'b1, 8'hA0, 1'b0, K_NONE);
    drive(1'b0, 8'h00, 1'b0, K_NONE);
    drive(1'b1, 8'h00, 1'b0, K_NONE);
    drive(1'b0, 8'h00, 1'b0, K_NONE);
    ce_set(1'b1);
    dq = '{8'h9A, 8'h9B};
    mq = '{1'b1, 1'b1};
    write_burst(32'h40, 0);
    bd_is(8'h40, 8'h9A);
    bd_is(8'h41, 8'h9B);
    cfg_rlc_i = 8'd1;
    cmd_addr(8'h20, 32'h30, 1);
    drive(1'b1, 8'h00, 1'b0, K_RD);
    drive(1'b0, 8'h00, 1'b0, K_RD);
    @(negedge clk_i);
    #2;
    chk("pre_rst_dqs_en", psram_dqs_en_o, 1'b1);
    chk_on = 1'b0;
    rst_n_i = 1'b0;
    psram_ce_i = 1'b1;
    psram_sck_i = 1'b0;
    #1;
    chk("arst_io_en", psram_io_en_o, 8'h00);
    chk("arst_dqs_en", psram_dqs_en_o, 1'b0);
    chk("arst_dqs_out", psram_dqs_out_o, 1'b0);
    chk("arst_io_out", psram_io_out_o, 8'h00);
    chk("arst_busy", busy_o, 1'b0);
    exp_busy = 1'b0;
    exp_en = 1'b0;
    exp_dqs = 1'b0;
    exp_err = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_on = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_i);
      bd_addr_i = 8'(i);
    end
    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/psram_slave_model.md
Name: psram_slave_model

Overview:
- Synthesizable octal-DDR PSRAM responder: the device-side counterpart of the PSRAM controller core.
- Oversamples psram_sck/ce/io/dqs in the clk_i domain, decodes command and address, and holds a byte-wide internal memory.
- Returns read bursts with a DQS strobe, and absorbs write bursts under a DQS byte mask.
- Used as an on-chip loopback target for SoC bring-up and as the DUT-side model in controller regressions.

Parameters:
- MEM_DEPTH, 256, number of bytes in the internal array (power of two).
- MEM_AW, $clog2(MEM_DEPTH), array index width; psram address bits above it are ignored.

Ports:
- clk_i  input  1  system clock; must be at least 4x psram_sck_i.
- rst_n_i  input  1  asynchronous active-low reset.
- cfg_rcmd_i  input  8  read command opcode.
- cfg_wcmd_i  input  8  write command opcode.
- cfg_rlc_i  input  8  read latency, in sck cycles.
- cfg_wlc_i  input  8  write latency, in sck cycles.
- psram_sck_i  input  1  PSRAM clock from the controller.
- psram_ce_i  input  1  chip enable, active low.
- psram_io_in_i  input  8  command/address/write data from the controller.
- psram_io_out_o  output  8  read data.
- psram_io_en_o  output  8  per-bit output enable, 1 = drive.
- psram_dqs_in_i  input  1  write byte mask, 1 = byte written.
- psram_dqs_out_o  output  1  read data strobe.
- psram_dqs_en_o  output  1  DQS output enable.
- bd_addr_i  input  MEM_AW  backdoor read index.
- bd_data_o  output  8  backdoor data, combinational mem[bd_addr_i].
- busy_o  output  1  state != IDLE.
- cmd_err_o  output  1  one-cycle pulse when an unknown opcode is received.

Behaviour:
- Reset values: all outputs 0. State = IDLE, address = 0, dqs_out = 0. The memory array is NOT reset.
- Edge detection:
  - sck_q is sck_i registered.
  - rise = sck_i & ~sck_q; fall = ~sck_i & sck_q; edge = rise | fall.
  - psram_io_in_i and psram_dqs_in_i are sampled in the same clk cycle as the edge. No synchronizers: same clock domain.
- Chip enable: if psram_ce_i = 1 in any state, the next state is IDLE. This aborts the transaction, drops both output enables, and leaves the memory unchanged beyond bytes already written.
- States and transitions:
  - IDLE: when ce = 0 -> INST.
  - INST: on the first rise, compare io against the opcodes.
    - Match cfg_rcmd_i -> ADDR, rd = 1.
    - Match cfg_wcmd_i -> ADDR, rd = 0.
    - Otherwise -> IGNORE and pulse cmd_err_o. If rcmd == wcmd, read wins.
  - ADDR: capture 4 bytes MSB first on successive edges (rise, fall, rise, fall), shifting into a 32-bit address register.
    - After the 4th byte, load lat_cnt with rd ? cfg_rlc_i : cfg_wlc_i -> LATN.
  - LATN: each rise decrements lat_cnt.
    - The rise seen while lat_cnt == 0 is the first data edge. It is processed as a data edge in that same cycle, and the state moves to RDATA or WDATA.
    - lc = 0 therefore means data starts on the first rise after the address.
  - WDATA: on each edge, if dqs_in = 1 then mem[addr[MEM_AW-1:0]] <= io_in. The address increments on every edge, masked or not.
  - RDATA: on each edge, register io_out <= mem[addr], toggle dqs_out, and increment the address.
    - io_en_o = 8'hFF and dqs_en_o = 1 from state entry until exit.
    - dqs_out is 0 on entry.
  - IGNORE: holds until ce = 1.
- Address arithmetic: a 32-bit increment with natural wrap. The array index wraps modulo MEM_DEPTH.
- Read data and dqs change in the same clk cycle, so a controller that edge-detects dqs sees the new byte stable.
- Bursts are unbounded and end only when ce rises. Edges arriving while ce = 1 are ignored.
- An edge arriving on the same cycle that ce rises is ignored; ce has priority.

Test Plan:
- Write burst, wcmd = 8'hA0, wlc = 2, addr 32'h0000_0010, bytes 11 22 33 44 with dqs = 1 -> bd_data at 0x10..0x13 = 11 22 33 44; busy_o falls 1 cycle after ce rises.
- Read burst, rcmd = 8'h20, rlc = 3, addr 32'h0000_0012, 4 data edges -> io_out = 33, 44, then mem[0x14], mem[0x15]; dqs_out toggles 4 times (0→1→0→1→0); io_en_o = FF only during RDATA.
- Masked write of AA BB CC DD to 0x20 with dqs pattern 1,0,1,0 -> mem[0x20] = AA, mem[0x21] unchanged, mem[0x22] = CC, mem[0x23] unchanged.
- Wrap: MEM_DEPTH = 256, write 2 bytes at 32'h0000_01FF -> mem[0xFF] and mem[0x00] written.
- Unknown opcode 8'h5A -> cmd_err_o pulses exactly once; subsequent edges cause no write; io_en_o stays 0.
- ce raised mid-address, then a new write with lc = 0 -> clean restart; the first data byte is captured on the first rise after address byte 4.
- rst_n_i asserted during RDATA -> io_en_o, dqs_en_o and dqs_out go to 0 immediately (asynchronous).
